// File: rtl/queue_drain_if.sv
// Queue-side status/command signals plus the drained-byte valid/ready output.
// "master" is the drain side; "slave" is the queue/downstream side.
interface queue_drain_if #(
  parameter int DW = 8
);
  logic [DW-1:0] q_tail;
  logic          q_empty;
  logic          q_valid;
  logic [2:0]    q_op;
  logic          q_apply;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  q_tail, q_empty, q_valid, out_ready,
    output q_op, q_apply, out_data, out_valid
  );

  modport slave (
    output q_tail, q_empty, q_valid, out_ready,
    input  q_op, q_apply, out_data, out_valid
  );
endinterface

// File: rtl/queue_drain.sv
// Pops the byte queue one element at a time and forwards each byte on a
// registered valid/ready output, tracking a running checksum and element count.
module queue_drain #(
  parameter int         DW     = 8,
  parameter logic [2:0] OP_POP = 3'b001,
  parameter logic [2:0] OP_NOP = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  queue_drain_if.master    bus,
  output logic [15:0]      sum,
  output logic [7:0]       count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          apply_q, apply_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [15:0]   sum_q, sum_d;
  logic [7:0]    count_q, count_d;

  logic slot_free;
  logic capture;

  assign slot_free = !valid_q || bus.out_ready;
  assign capture   = (state_q == S_IDLE) && en && bus.q_valid && !bus.q_empty && slot_free;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d = state_q;
    apply_d = 1'b0;
    op_d    = OP_NOP;
    data_d  = data_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    count_d = count_q;

    if (capture) begin
      data_d  = bus.q_tail;
      valid_d = 1'b1;
      apply_d = 1'b1;
      op_d    = OP_POP;
      sum_d   = sum_q + 16'(bus.q_tail);
      count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      state_d = S_WAIT;
    end else begin
      // An accepted byte is retired in either state so it is never presented twice.
      if (valid_q && bus.out_ready) valid_d = 1'b0;
      if (state_q == S_WAIT) state_d = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, including the data path, is reset so the outputs are defined immediately.
      state_q <= S_IDLE;
      apply_q <= 1'b0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      apply_q <= apply_d;
      op_q    <= op_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign bus.q_apply   = apply_q;
  assign bus.q_op      = op_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign sum           = sum_q;
  assign count         = count_q;

endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain: a small array-backed queue model answers the
// pop commands, and every accepted output byte is logged for ordering checks.
module tb_queue_drain;

  localparam logic [2:0] OP_POP = 3'b001;
  localparam logic [2:0] OP_NOP = 3'b000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] sum;
  logic [7:0]  count;

  queue_drain_if #(.DW(8)) bus ();

  queue_drain #(.DW(8), .OP_POP(OP_POP), .OP_NOP(OP_NOP)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .bus   (bus),
    .sum   (sum),
    .count (count)
  );

  always #5 clk = ~clk;

  // Queue model: written by the stimulus, popped by the DUT's commands.
  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       valid_en = 1'b1;

  assign bus.q_tail  = (rd_ptr != wr_ptr) ? mem[rd_ptr[9:0]] : 8'h00;
  assign bus.q_empty = (rd_ptr == wr_ptr);
  assign bus.q_valid = (rd_ptr != wr_ptr) && valid_en;

  int   pops       = 0;
  int   empty_pops = 0;
  int   b2b        = 0;
  logic prev_apply = 1'b0;

  always @(posedge clk) begin
    if (bus.q_apply && bus.q_op == OP_POP) begin
      pops <= pops + 1;
      if (rd_ptr == wr_ptr) empty_pops <= empty_pops + 1;
      else                  rd_ptr     <= rd_ptr + 1;
    end
    if (bus.q_apply && prev_apply) b2b <= b2b + 1;
    prev_apply <= bus.q_apply;
  end

  logic [7:0] acc [0:1023];
  int         acc_n = 0;

  always @(posedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      acc[acc_n[9:0]] <= bus.out_data;
      acc_n           <= acc_n + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  logic [7:0] drain3 [0:2] = '{8'h0A, 8'h11, 8'h19};
  logic [7:0] bp     [0:4] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};

  initial begin
    int p0;
    rst           = 1'b0;
    en            = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, asserted before any clock edge
    #3;
    check("rst_apply", 32'(bus.q_apply), 32'd0);
    check("rst_op",    32'(bus.q_op),    32'(OP_NOP));
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_sum",   32'(sum),   32'd0);
    check("rst_count", 32'(count), 32'd0);
    tick();
    rst = 1'b1;

    // Drain three bytes with the output always ready
    foreach (drain3[i]) push(drain3[i]);
    en            = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d3_apply", 32'(bus.q_apply), 32'd1);
      check("d3_op",    32'(bus.q_op),    32'(OP_POP));
      check("d3_valid", 32'(bus.out_valid), 32'd1);
      check("d3_data",  32'(bus.out_data),  32'(drain3[i]));
      tick();
      check("d3_gap",   32'(bus.q_apply), 32'd0);
    end
    repeat (4) begin
      tick();
      check("d3_nopop", 32'(bus.q_apply), 32'd0);
    end
    check("d3_pops",  32'(pops),  32'd3);
    check("d3_sum",   32'(sum),   32'h0034);
    check("d3_count", 32'(count), 32'd3);
    check("d3_acc_n", 32'(acc_n), 32'd3);

    // Backpressure: one byte captured, then the output stalls for 10 cycles
    bus.out_ready = 1'b0;
    foreach (bp[i]) push(bp[i]);
    tick();
    check("bp_first", 32'(bus.out_data), 32'h21);
    check("bp_apply", 32'(bus.q_apply), 32'd1);
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_data",  32'(bus.out_data),  32'h21);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_apply", 32'(bus.q_apply),   32'd0);
    end
    check("bp_one_pop", 32'(pops - p0), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("bp_rel_data",  32'(bus.out_data),  32'(bp[i]));
      check("bp_rel_valid", 32'(bus.out_valid), 32'd1);
      check("bp_rel_apply", 32'(bus.q_apply),   32'd1);
      tick();
      check("bp_rel_gap",   32'(bus.q_apply),   32'd0);
    end
    tick();
    check("bp_acc_n", 32'(acc_n), 32'd8);
    for (int i = 0; i < 5; i++) check("bp_acc", 32'(acc[3 + i]), 32'(bp[i]));
    check("bp_sum",   32'(sum),   32'h0183);
    check("bp_count", 32'(count), 32'd8);

    // en low while the queue becomes non-empty: nothing is popped until it rises
    en = 1'b0;
    push(8'h77);
    p0 = pops;
    repeat (3) begin
      tick();
      check("en_off_apply", 32'(bus.q_apply), 32'd0);
    end
    check("en_off_pops", 32'(pops - p0), 32'd0);
    en = 1'b1;
    tick();
    check("en_on_data",  32'(bus.out_data), 32'h77);
    check("en_on_apply", 32'(bus.q_apply),  32'd1);
    tick();

    // q_valid low on a non-empty queue blocks popping; en dropped during WAIT
    valid_en = 1'b0;
    push(8'h88);
    push(8'h99);
    p0 = pops;
    repeat (3) begin
      tick();
      check("qv_off_apply", 32'(bus.q_apply), 32'd0);
    end
    valid_en = 1'b1;
    tick();
    check("qv_on_data",  32'(bus.out_data), 32'h88);
    check("qv_on_apply", 32'(bus.q_apply),  32'd1);
    en = 1'b0;
    tick();
    check("enw_apply", 32'(bus.q_apply), 32'd0);
    repeat (3) begin
      tick();
      check("enw_nopop", 32'(bus.q_apply), 32'd0);
    end
    check("enw_pops", 32'(pops - p0), 32'd1);
    en = 1'b1;
    tick();
    check("enw_resume", 32'(bus.out_data), 32'h99);
    tick();
    check("enw_sum",   32'(sum),   32'h031B);
    check("enw_count", 32'(count), 32'd11);

    // Reset asserted in the WAIT cycle
    push(8'h5A);
    push(8'h6B);
    tick();
    check("rw_pre_apply", 32'(bus.q_apply), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rw_apply", 32'(bus.q_apply),   32'd0);
    check("rw_op",    32'(bus.q_op),      32'(OP_NOP));
    check("rw_valid", 32'(bus.out_valid), 32'd0);
    check("rw_data",  32'(bus.out_data),  32'd0);
    check("rw_sum",   32'(sum),   32'd0);
    check("rw_count", 32'(count), 32'd0);
    tick();
    check("rw_held_apply", 32'(bus.q_apply), 32'd0);
    rst = 1'b1;
    tick();
    check("rw_restart_data", 32'(bus.out_data), 32'h5A);
    check("rw_restart_sum",  32'(sum),   32'h005A);
    check("rw_restart_cnt",  32'(count), 32'd1);
    tick();
    tick();
    check("rw_next_data", 32'(bus.out_data), 32'h6B);
    check("rw_next_sum",  32'(sum),   32'h00C5);
    check("rw_next_cnt",  32'(count), 32'd2);
    tick();

    // Saturation: fresh reset, then 300 bytes of 0xFF
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 300; i++) push(8'hFF);
    for (int i = 0; i < 800; i++) begin
      tick();
      if (rd_ptr == wr_ptr && !bus.q_apply) break;
    end
    tick();
    tick();
    check("sat_drained", 32'(rd_ptr), 32'(wr_ptr));
    check("sat_count",   32'(count), 32'd255);
    check("sat_sum",     32'(sum),   32'h2AD4);

    // Global protocol invariants over the whole run
    check("tot_pops",       32'(pops),       32'd313);
    check("tot_acc",        32'(acc_n),      32'd313);
    check("no_empty_pops",  32'(empty_pops), 32'd0);
    check("no_b2b_apply",   32'(b2b),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_drain.md
# queue_drain

Downstream consumer of the byte queue. Watches the queue's `tail`/`empty`/`valid` status and issues one-cycle pop commands on its `op`/`apply` port. Each popped byte is forwarded on a registered valid/ready output. A 16-bit wrap-around checksum and a saturating element count are kept over everything drained since reset.

## Interface
- `DW`, 8: data width; must match the queue's `tail` width.
- `OP_POP`, 3'b001: op code driven on `q_op` to remove the tail element.
- `OP_NOP`, 3'b000: op code driven on `q_op` when no pop is issued.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; one clock; no other reset.
- `en`  in  1  drain enable; low means no new pop is started.
- `q_tail`  in  DW  current tail element of the queue.
- `q_empty`  in  1  queue holds no elements.
- `q_valid`  in  1  `q_tail` holds a valid element.
- `q_op`  out  3  command to the queue.
- `q_apply`  out  1  command strobe to the queue.
- `out_data`  out  DW  drained byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `sum`  out  16  wrap-around sum of all drained bytes, zero-extended.
- `count`  out  8  number of bytes drained, saturating at 255.

## Operation
- FSM has two states.
  - IDLE: may start a pop.
  - WAIT: lets the queue apply the pop and update its status outputs.
- All outputs are registered.
- Reset (`rst`=0) forces, immediately and regardless of `clk`:
  - state = IDLE;
  - `q_apply`=0, `q_op`=`OP_NOP`;
  - `out_data`=0, `out_valid`=0;
  - `sum`=0, `count`=0.
- Output slot free = `!out_valid || out_ready`.
- Capture condition, evaluated in IDLE: `en && q_valid && !q_empty && slot free`. When it holds, at the next edge:
  - `out_data` <= `q_tail`, `out_valid` <= 1;
  - `q_apply` <= 1, `q_op` <= `OP_POP`;
  - `sum` <= `sum` + `q_tail` (mod 2^16);
  - `count` <= min(`count`+1, 255);
  - state <= WAIT.
- In WAIT, at the next edge:
  - `q_apply` <= 0, `q_op` <= `OP_NOP`;
  - state <= IDLE, unconditionally.
- When the capture condition is false in IDLE:
  - `q_apply`/`q_op` stay 0/`OP_NOP`;
  - if `out_valid && out_ready`, `out_valid` <= 0.
- Output hold: while `out_valid && !out_ready`, `out_data` must not change.
- Boundary cases:
  - Empty queue (`q_empty`=1 or `q_valid`=0): no pop is issued; never pop an empty queue.
  - `en` dropped during WAIT: WAIT still completes; no further pop is issued.
  - Simultaneous accept and capture (`out_valid && out_ready` with the capture condition true): the new byte replaces the old one and `out_valid` stays 1. No bubble, no loss.
  - Backpressure: with `out_ready`=0 and `out_valid`=1, no pop is issued, so the queue is not drained while the output is full.
  - `count` saturated at 255: `sum` still accumulates.
  - Reset mid-WAIT: `q_apply` drops immediately. The queue may or may not have seen the strobe; it is reset by its own reset in the system.

## Timing
- `q_apply` is high for exactly one cycle per pop.
- `q_apply` is never high in two consecutive cycles.
- Latency: capture condition true in cycle N gives `out_data`/`out_valid`/`q_apply` valid in cycle N+1.
- The queue samples the pop at the end of cycle N+1. Its updated `q_tail`/`q_empty` are seen in cycle N+2 (IDLE), where the next capture can be decided.
- Maximum throughput is 1 byte per 2 cycles.
- `sum` and `count` update in the same cycle that `out_valid` rises for the new byte.

## Test plan
- Reset values: drive `rst`=0 mid-cycle. All outputs go to 0/`OP_NOP` before the next edge; `q_apply`=0 while `rst`=0.
- Drain 3 bytes, `out_ready`=1, `en`=1.
  - Stimulus: queue model holds 0x0A, 0x11, 0x19 (tail first); `q_apply` pulses and `out_valid` rise in cycles 1, 3, 5.
  - Response: `out_data` = 0x0A, 0x11, 0x19; then `q_empty`=1 and no further pop.
  - Final `sum` = 0x0034, `count` = 3.
- Backpressure: `out_ready`=0 after the first byte, with 5 bytes queued.
  - While `out_ready`=0: exactly one `q_apply` pulse, and `out_data` stays stable for 10 cycles.
  - On release: one byte every 2 cycles and no byte is lost.
- `en` toggling: drop `en` in the cycle the capture condition first holds, so no pop is issued; raise `en` and draining resumes.
- Saturation: drain 300 bytes of 0xFF.
  - `count` sticks at 255.
  - `sum` = (300·255) mod 65536 = 0x2AD4.
- Reset mid-operation: assert `rst` in the WAIT cycle.
  - `q_apply` drops without waiting for a clock edge.
  - After release, `sum`=0, `count`=0, and draining restarts from the queue's current contents.
